// File: rtl/golden_nonce_reporter_pkg.sv
// Shared constants and FSM encoding for the golden-nonce UART return path.
// Imported by the top level, the byte serialiser and the testbench.
package golden_nonce_reporter_pkg;

  localparam int NONCE_W            = 32;
  localparam int UART_BITS_PER_BYTE = 8;
  localparam int BYTES_PER_NONCE    = 4;

  localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_NONCE - 1);
  localparam logic [2:0] LAST_BIT_IDX  = 3'(UART_BITS_PER_BYTE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Saturating increment so that a flood of overflows never wraps back to a small count.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/nonce_uart_tx.sv
// Byte-level 8N1 serialiser. A load in IDLE, or in the last STOP cycle, starts a new byte
// with no gap; done pulses during the final cycle of the stop bit.
module nonce_uart_tx
  import golden_nonce_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       hash_clk,
  input  logic       reset_n,
  input  logic [7:0] tx_byte,
  input  logic       load,
  output logic       txd,
  output logic       done,
  output tx_state_e  state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_sr;
  logic             bit_end;

  assign bit_end = (clk_cnt == LAST_CNT);
  assign done    = (state == STOP) && bit_end;

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      txd     <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      data_sr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state   <= START;
            txd     <= 1'b0;
            clk_cnt <= '0;
            data_sr <= tx_byte;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            txd     <= data_sr[0];
            clk_cnt <= '0;
            bit_idx <= '0;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == LAST_BIT_IDX) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              // LSB-first: shift right and present the next bit.
              bit_idx <= bit_idx + 3'd1;
              data_sr <= {1'b0, data_sr[7:1]};
              txd     <= data_sr[1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (load) begin
              state   <= START;
              txd     <= 1'b0;
              data_sr <= tx_byte;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/golden_nonce_reporter.sv
// Captures golden nonces on the rising edge of golden_nonce_match, buffers them in a small
// FIFO and returns each one to the host as four 8N1 bytes, most significant byte first.
module golden_nonce_reporter
  import golden_nonce_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               hash_clk,
  input  logic               reset_n,
  input  logic [NONCE_W-1:0] golden_nonce,
  input  logic               golden_nonce_match,
  output logic               txd,
  output logic               tx_busy,
  output logic               fifo_full,
  output logic [7:0]         drop_cnt,
  output tx_state_e          dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Handshake: a push is a one-cycle strobe from the edge detector with no backpressure;
  // a pop happens only when the serialiser is IDLE and the FIFO is non-empty, and the
  // popped head is loaded into the serialiser on that same edge.
  logic               match_s;
  logic               match_q;
  logic [NONCE_W-1:0] nonce_s;

  logic [NONCE_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [AW:0]        wr_ptr_nxt, rd_ptr_nxt;
  logic               fifo_empty, full_now, full_nxt;
  logic [NONCE_W-1:0] head;

  logic               push, pop, accept, drop;
  logic               next_byte, load, tx_done, busy_nxt;
  logic [7:0]         load_byte;
  logic [23:0]        rest_sr;
  logic [1:0]         byte_idx;

  assign push       = match_s & ~match_q;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign full_now   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];

  assign pop       = (dbg_state == IDLE) && !fifo_empty;
  assign next_byte = tx_done && (byte_idx != LAST_BYTE_IDX);
  assign load      = pop | next_byte;
  assign load_byte = pop ? head[31:24] : rest_sr[23:16];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign accept = push & (~full_now | pop);
  assign drop   = push & full_now & ~pop;

  assign wr_ptr_nxt = wr_ptr + (AW+1)'(accept);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(pop);
  assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
  assign busy_nxt   = (wr_ptr_nxt != rd_ptr_nxt) | load |
                      ((dbg_state != IDLE) & ~tx_done);

  always_ff @(posedge hash_clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= nonce_s;
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      match_s   <= 1'b0;
      match_q   <= 1'b0;
      nonce_s   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_full <= 1'b0;
      tx_busy   <= 1'b0;
      drop_cnt  <= '0;
      rest_sr   <= '0;
      byte_idx  <= '0;
    end else begin
      match_s   <= golden_nonce_match;
      match_q   <= match_s;
      nonce_s   <= golden_nonce;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      fifo_full <= full_nxt;
      tx_busy   <= busy_nxt;
      if (drop) drop_cnt <= sat_inc8(drop_cnt);
      // rest_sr keeps the bytes still to be sent, next one in the top lane.
      if (pop) begin
        rest_sr  <= head[23:0];
        byte_idx <= '0;
      end else if (next_byte) begin
        rest_sr  <= {rest_sr[15:0], 8'h00};
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  nonce_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .hash_clk(hash_clk),
    .reset_n (reset_n),
    .tx_byte (load_byte),
    .load    (load),
    .txd     (txd),
    .done    (tx_done),
    .state   (dbg_state)
  );

endmodule
